// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: serialises bundle memory slots 3 and 4 onto one data-memory port.
// Ports: decode-reg slot requests in, m_* memory port, mem_stall and wb_* writeback out.
module mem_slot_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int RD_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mre3,
  input  logic              mwe3,
  input  logic [ADDR_W-1:0] daddr3,
  input  logic [DATA_W-1:0] wdata3,
  input  logic [RD_W-1:0]   rd3,
  input  logic              mre4,
  input  logic              mwe4,
  input  logic [ADDR_W-1:0] daddr4,
  input  logic [DATA_W-1:0] wdata4,
  input  logic [RD_W-1:0]   rd4,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              mem_stall,
  output logic [RD_W-1:0]   wb_rd3,
  output logic [RD_W-1:0]   wb_rd4,
  output logic [DATA_W-1:0] wb_memdata3,
  output logic [DATA_W-1:0] wb_memdata4
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE3, S_WAIT3, S_ISSUE4, S_WAIT4, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic              ld3_q, st3_q, ld4_q, st4_q;
  logic [ADDR_W-1:0] addr3_q, addr4_q;
  logic [DATA_W-1:0] wdata3_q, wdata4_q;
  logic [RD_W-1:0]   rd3_q, rd4_q;
  logic [DATA_W-1:0] res3_q, res4_q;

  logic              m_req_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [RD_W-1:0]   wb_rd3_q, wb_rd4_q;
  logic [DATA_W-1:0] wb_md3_q, wb_md4_q;

  logic idle, busy, bv;
  logic act3_in, act4_q;
  logic rv3, rv4;

  // Payload of the next issue: live inputs while capturing, else captured regs.
  logic              p_st3, p_st4;
  logic [ADDR_W-1:0] p_addr3, p_addr4;
  logic [DATA_W-1:0] p_wdata3, p_wdata4;
  logic [DATA_W-1:0] r3_now, r4_now;

  assign idle    = (state_q == S_IDLE);
  assign busy    = (state_q == S_ISSUE3) | (state_q == S_WAIT3)
                 | (state_q == S_ISSUE4) | (state_q == S_WAIT4);
  assign bv      = mre3 | mwe3 | mre4 | mwe4;
  assign act3_in = mre3 | mwe3;
  assign act4_q  = ld4_q | st4_q;
  assign rv3     = (state_q == S_WAIT3) & m_rvalid;
  assign rv4     = (state_q == S_WAIT4) & m_rvalid;

  // A load wins if both enables of one slot are set.
  assign p_st3    = idle ? (mwe3 & ~mre3) : st3_q;
  assign p_st4    = idle ? (mwe4 & ~mre4) : st4_q;
  assign p_addr3  = idle ? daddr3 : addr3_q;
  assign p_addr4  = idle ? daddr4 : addr4_q;
  assign p_wdata3 = idle ? wdata3 : wdata3_q;
  assign p_wdata4 = idle ? wdata4 : wdata4_q;

  // Last read may complete on the same edge that enters DONE.
  assign r3_now = rv3 ? m_rdata : res3_q;
  assign r4_now = rv4 ? m_rdata : res4_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bv) state_d = act3_in ? S_ISSUE3 : S_ISSUE4;
      S_ISSUE3: if (m_gnt)
                  state_d = ld3_q  ? S_WAIT3 :
                            act4_q ? S_ISSUE4 : S_DONE;
      S_WAIT3:  if (m_rvalid) state_d = act4_q ? S_ISSUE4 : S_DONE;
      S_ISSUE4: if (m_gnt) state_d = ld4_q ? S_WAIT4 : S_DONE;
      S_WAIT4:  if (m_rvalid) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ld3_q     <= 1'b0;
      st3_q     <= 1'b0;
      ld4_q     <= 1'b0;
      st4_q     <= 1'b0;
      addr3_q   <= '0;
      addr4_q   <= '0;
      wdata3_q  <= '0;
      wdata4_q  <= '0;
      rd3_q     <= '0;
      rd4_q     <= '0;
      res3_q    <= '0;
      res4_q    <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      wb_rd3_q  <= '0;
      wb_rd4_q  <= '0;
      wb_md3_q  <= '0;
      wb_md4_q  <= '0;
    end else begin
      state_q <= state_d;
      if (idle && bv) begin
        ld3_q    <= mre3;
        st3_q    <= mwe3 & ~mre3;
        ld4_q    <= mre4;
        st4_q    <= mwe4 & ~mre4;
        addr3_q  <= daddr3;
        addr4_q  <= daddr4;
        wdata3_q <= wdata3;
        wdata4_q <= wdata4;
        rd3_q    <= rd3;
        rd4_q    <= rd4;
      end
      if (rv3) res3_q <= m_rdata;
      if (rv4) res4_q <= m_rdata;

      m_req_q <= (state_d == S_ISSUE3) | (state_d == S_ISSUE4);
      case (state_d)
        S_ISSUE3: begin
          m_we_q    <= p_st3;
          m_addr_q  <= p_addr3;
          m_wdata_q <= p_wdata3;
        end
        S_ISSUE4: begin
          m_we_q    <= p_st4;
          m_addr_q  <= p_addr4;
          m_wdata_q <= p_wdata4;
        end
        default: begin
          m_we_q    <= 1'b0;
          m_addr_q  <= '0;
          m_wdata_q <= '0;
        end
      endcase

      if (state_d == S_DONE) begin
        wb_rd3_q <= ld3_q ? rd3_q  : '0;
        wb_md3_q <= ld3_q ? r3_now : '0;
        wb_rd4_q <= ld4_q ? rd4_q  : '0;
        wb_md4_q <= ld4_q ? r4_now : '0;
      end else begin
        wb_rd3_q <= '0;
        wb_md3_q <= '0;
        wb_rd4_q <= '0;
        wb_md4_q <= '0;
      end
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign wb_rd3      = wb_rd3_q;
  assign wb_rd4      = wb_rd4_q;
  assign wb_memdata3 = wb_md3_q;
  assign wb_memdata4 = wb_md4_q;

  // DONE releases the pipeline; the still-presented bundle is not recaptured.
  assign mem_stall = ~rst & ((idle & bv) | busy);

endmodule
